// File: rtl/fp_mult_pkg.sv
// Shared types and parameter-derived constants for the iterative floating-point multiplier.
package fp_mult_pkg;

  typedef enum logic [2:0] {IDLE, MUL, NORM, RND, DONE} state_t;

  typedef enum logic [2:0] {ZERO, NORMAL, INF, QNAN, SNAN} fp_class_t;

  // Wide enough for any format instance; callers slice down to their own width.
  localparam int MAX_W = 128;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int iter_count(input int man_w, input int radix_bits);
    return (man_w + radix_bits) / radix_bits;
  endfunction

  function automatic logic [MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
    v[man_w-1] = 1'b1;
    return v;
  endfunction

  // Unsigned infinity magnitude; the sign bit is attached by the user.
  function automatic logic [MAX_W-1:0] inf_bits(input int exp_w, input int man_w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Splits an IEEE-754 operand into sign, exponent, mantissa with hidden bit and its class.
module fp_classify
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       mant,
  output logic [2:0]           cls
);

  logic [MAN_W-1:0] frac;

  always_comb begin
    sign = op[EXP_W+MAN_W];
    expo = op[EXP_W+MAN_W-1:MAN_W];
    frac = op[MAN_W-1:0];
    mant = {1'b1, frac};
    cls  = NORMAL;
    // Subnormals collapse into ZERO: they are flushed without a flag.
    if (expo == '0) begin
      cls  = ZERO;
      mant = '0;
    end else if (&expo) begin
      if (frac == '0)          cls = INF;
      else if (frac[MAN_W-1])  cls = QNAN;
      else                     cls = SNAN;
    end
  end

endmodule

// File: rtl/mult_fp_iter.sv
// Iterative IEEE-754 multiplier: radix-2^RADIX_BITS shift-add mantissa product,
// round-to-nearest-even, special-case bypass and valid/ready on both sides.
module mult_fp_iter
  import fp_mult_pkg::*;
#(
  parameter int EXP_W      = 11,
  parameter int MAN_W      = 52,
  parameter int RADIX_BITS = 2
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_valid,
  output logic                 O_ready,
  input  logic [EXP_W+MAN_W:0] I_a,
  input  logic [EXP_W+MAN_W:0] I_b,
  output logic                 O_valid,
  input  logic                 I_ready,
  output logic [EXP_W+MAN_W:0] O_result,
  output logic                 O_over_flow,
  output logic                 O_under_flow,
  output logic                 O_invalid
);

  localparam int W     = EXP_W + MAN_W + 1;
  localparam int MW    = MAN_W + 1;
  localparam int PW    = 2 * MW;
  localparam int N     = iter_count(MAN_W, RADIX_BITS);
  localparam int MPW   = N * RADIX_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int EW    = EXP_W + 2;
  localparam int BIAS  = bias_of(EXP_W);

  localparam logic [MAX_W-1:0]     QNAN_FULL = qnan_bits(EXP_W, MAN_W);
  localparam logic [MAX_W-1:0]     INF_FULL  = inf_bits(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN_RES  = QNAN_FULL[W-1:0];
  localparam logic [W-2:0]         INF_MAG   = INF_FULL[W-2:0];
  localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE       = EW'(1);

  function automatic logic [MW:0] round_rne(input logic [MW-1:0] m, input logic g,
                                            input logic r, input logic s);
    return {1'b0, m} + (MW+1)'(g & (r | s | m[0]));
  endfunction

  // Returns {overflow, underflow, packed result}.
  function automatic logic [W+1:0] saturate(input logic s, input logic signed [EW-1:0] e,
                                            input logic [MAN_W-1:0] m);
    if (e >= EXP_MAX) return {2'b10, s, INF_MAG};
    if (e <= 0)       return {2'b01, s, {(W-1){1'b0}}};
    return {2'b00, s, e[EXP_W-1:0], m};
  endfunction

  state_t state;
  logic [CNT_W-1:0] cnt;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   ma, mb;
  logic [2:0]       ca, cb;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op(I_a), .sign(sa), .expo(ea), .mant(ma), .cls(ca)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op(I_b), .sign(sb), .expo(eb), .mant(mb), .cls(cb)
  );

  logic                 special, spec_inv;
  logic [W-1:0]         spec_res;
  logic signed [EW-1:0] exp_sum;
  logic                 sgn, a_nan, b_nan;

  assign sgn     = sa ^ sb;
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

  always_comb begin
    a_nan    = (ca == QNAN) || (ca == SNAN);
    b_nan    = (cb == QNAN) || (cb == SNAN);
    special  = 1'b1;
    spec_inv = 1'b0;
    spec_res = '0;
    if (a_nan || b_nan) begin
      spec_res = QNAN_RES;
      spec_inv = (ca == SNAN) || (cb == SNAN);
    end else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
      spec_res = QNAN_RES;
      spec_inv = 1'b1;
    end else if (ca == INF || cb == INF) begin
      spec_res = {sgn, INF_MAG};
    end else if (ca == ZERO || cb == ZERO) begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  logic                 prod_sign;
  logic signed [EW-1:0] prod_exp;
  logic [PW-1:0]        ma_sh, acc, partial, norm;
  logic [MPW-1:0]       mplier;
  logic [MW-1:0]        mant;
  logic                 guard, rnd, sticky;
  logic [MW:0]          rounded;
  logic signed [EW-1:0] exp_r;
  logic [MAN_W-1:0]     man_r;
  logic [W+1:0]         packed_res;

  // Multiplicand slides left while multiplier digits are retired from its LSB end.
  assign partial = ma_sh * PW'(mplier[RADIX_BITS-1:0]);
  assign norm    = acc[PW-1] ? acc : {acc[PW-2:0], 1'b0};

  always_comb begin
    rounded    = round_rne(mant, guard, rnd, sticky);
    exp_r      = rounded[MW] ? prod_exp + ONE : prod_exp;
    man_r      = rounded[MW] ? rounded[MW-1:1] : rounded[MAN_W-1:0];
    packed_res = saturate(prod_sign, exp_r, man_r);
  end

  always_ff @(posedge I_clk) begin
    case (state)
      IDLE: if (I_valid) begin
        prod_sign <= sgn;
        prod_exp  <= exp_sum;
        ma_sh     <= PW'(ma);
        mplier    <= MPW'(mb);
        acc       <= '0;
      end
      MUL: begin
        acc    <= acc + partial;
        ma_sh  <= ma_sh << RADIX_BITS;
        mplier <= mplier >> RADIX_BITS;
      end
      NORM: begin
        mant   <= norm[PW-1:MW];
        guard  <= norm[MW-1];
        rnd    <= norm[MW-2];
        sticky <= |norm[MW-3:0];
        if (acc[PW-1]) prod_exp <= prod_exp + ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      O_valid      <= 1'b0;
      O_result     <= '0;
      O_over_flow  <= 1'b0;
      O_under_flow <= 1'b0;
      O_invalid    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (I_valid) begin
          O_over_flow  <= 1'b0;
          O_under_flow <= 1'b0;
          O_invalid    <= 1'b0;
          cnt          <= '0;
          if (special) begin
            O_result  <= spec_res;
            O_invalid <= spec_inv;
            O_valid   <= 1'b1;
            state     <= DONE;
          end else begin
            state <= MUL;
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) state <= NORM;
        end
        NORM: state <= RND;
        RND: begin
          O_over_flow  <= packed_res[W+1];
          O_under_flow <= packed_res[W];
          O_result     <= packed_res[W-1:0];
          O_valid      <= 1'b1;
          state        <= DONE;
        end
        DONE: if (I_ready) begin
          O_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign O_ready = (state == IDLE);

endmodule
